// File: rtl/mac_pkg.sv
// Shared defaults, host FSM state encoding and matrix types for the mac_top host
// controller slice.
package mac_pkg;

   localparam int unsigned param_M            = 4;
   localparam int unsigned param_K            = 4;
   localparam int unsigned param_N            = 4;
   localparam int unsigned DATA_WIDTH_INITIAL = 8;
   localparam int unsigned DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WRITE,
      S_WAIT_DONE,
      S_GAP,
      S_READ,
      S_CAPTURE,
      S_RESP
   } host_state_t;

   typedef logic [param_M*param_K-1:0][DATA_WIDTH_INITIAL-1:0] a_mat_t;
   typedef logic [param_K*param_N-1:0][DATA_WIDTH_INITIAL-1:0] b_mat_t;
   typedef logic [param_M*param_N-1:0][DATA_WIDTH_FINAL-1:0]   c_mat_t;

endpackage

// File: rtl/mac_host_ctrl_if.sv
// Job/result handshake plus mac_top host bus. The master modport is the controller
// side; the slave modport is the front end / mac_top side.
interface mac_host_ctrl_if #(
   parameter int unsigned M   = 4,
   parameter int unsigned K   = 4,
   parameter int unsigned N   = 4,
   parameter int unsigned DWI = 8,
   parameter int unsigned DWF = 16
) ();

   logic                      job_val;
   logic                      job_rdy;
   logic [M*K-1:0][DWI-1:0]   job_a;
   logic [K*N-1:0][DWI-1:0]   job_b;
   logic                      res_val;
   logic                      res_rdy;
   logic [M*N-1:0][DWF-1:0]   res_c;
   logic                      res_timeout;
   logic                      host2block_val;
   logic                      host2block_rdy;
   logic [M*K-1:0][DWI-1:0]   a_data_in_ext;
   logic [K*N-1:0][DWI-1:0]   b_data_in_ext;
   logic                      a_b_we_ext;
   logic                      mac_done;
   logic                      block2host_val;
   logic                      block2host_rdy;
   logic                      c_re_ext;
   logic [M*N-1:0][DWF-1:0]   c_data_out_ext;

   modport master (
      input  job_val, job_a, job_b, res_rdy,
      input  host2block_rdy, mac_done, block2host_val, c_data_out_ext,
      output job_rdy, res_val, res_c, res_timeout,
      output host2block_val, a_data_in_ext, b_data_in_ext, a_b_we_ext,
      output block2host_rdy, c_re_ext
   );

   modport slave (
      output job_val, job_a, job_b, res_rdy,
      output host2block_rdy, mac_done, block2host_val, c_data_out_ext,
      input  job_rdy, res_val, res_c, res_timeout,
      input  host2block_val, a_data_in_ext, b_data_in_ext, a_b_we_ext,
      input  block2host_rdy, c_re_ext
   );

endinterface

// File: rtl/mac_matrix_transpose.sv
// Pure index remap of a row-major K x N matrix into row-major N x K.
module mac_matrix_transpose #(
   parameter int unsigned K = 4,
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) (
   input  logic [K*N-1:0][W-1:0] in_mat,
   output logic [K*N-1:0][W-1:0] out_mat
);

   for (genvar i = 0; i < K; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         assign out_mat[j*K+i] = in_mat[i*N+j];
      end
   end

endmodule

// File: rtl/mac_host_ctrl.sv
// Host-side initiator for mac_top: takes a job, runs request / write / wait / read,
// and returns C or a timeout flag on the result port.
module mac_host_ctrl #(
   parameter int unsigned param_M            = mac_pkg::param_M,
   parameter int unsigned param_K            = mac_pkg::param_K,
   parameter int unsigned param_N            = mac_pkg::param_N,
   parameter int unsigned DATA_WIDTH_INITIAL = mac_pkg::DATA_WIDTH_INITIAL,
   parameter int unsigned DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2,
   parameter bit          TRANSPOSE_B        = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
   input logic           clk,
   input logic           rst,
   mac_host_ctrl_if.master bus
);
   import mac_pkg::*;

   localparam int unsigned CW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned DWI = DATA_WIDTH_INITIAL;
   localparam int unsigned DWF = DATA_WIDTH_FINAL;

   host_state_t state_q, state_d;
   logic [CW-1:0]                         cnt_q;
   logic [param_M*param_K-1:0][DWI-1:0]   a_q;
   logic [param_K*param_N-1:0][DWI-1:0]   b_q, b_in;
   logic [param_M*param_N-1:0][DWF-1:0]   c_q;
   logic                                  to_q;
   logic                                  cnt_hit, timeout_evt;

   if (TRANSPOSE_B) begin : g_tr
      mac_matrix_transpose #(.K(param_K), .N(param_N), .W(DWI)) u_tr (
         .in_mat  (bus.job_b),
         .out_mat (b_in)
      );
   end else begin : g_pass
      assign b_in = bus.job_b;
   end

   assign cnt_hit = (cnt_q == CW'(TIMEOUT_CYCLES));

   // The exit condition is checked first so it wins over a same-cycle timeout.
   always_comb begin
      state_d     = state_q;
      timeout_evt = 1'b0;
      case (state_q)
         S_IDLE:      if (bus.job_val) state_d = S_REQ;
         S_REQ: begin
            if (bus.host2block_rdy) state_d = S_WRITE;
            else if (cnt_hit) begin
               state_d     = S_RESP;
               timeout_evt = 1'b1;
            end
         end
         S_WRITE:     state_d = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (bus.mac_done) state_d = S_GAP;
            else if (cnt_hit) begin
               state_d     = S_RESP;
               timeout_evt = 1'b1;
            end
         end
         S_GAP:       state_d = S_READ;
         S_READ:      state_d = S_CAPTURE;
         S_CAPTURE:   state_d = S_RESP;
         S_RESP:      if (bus.res_rdy) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_d != state_q) && (state_d == S_REQ || state_d == S_WAIT_DONE))
            cnt_q <= '0;
         else if ((state_q == S_REQ || state_q == S_WAIT_DONE) && !cnt_hit)
            cnt_q <= cnt_q + CW'(1);
         if (state_q == S_IDLE && bus.job_val) begin
            a_q  <= bus.job_a;
            b_q  <= b_in;
            to_q <= 1'b0;
         end
         if (state_q == S_CAPTURE) c_q <= bus.c_data_out_ext;
         if (timeout_evt) begin
            to_q <= 1'b1;
            c_q  <= '0;
         end
      end
   end

   assign bus.job_rdy        = (state_q == S_IDLE);
   assign bus.res_val        = (state_q == S_RESP);
   assign bus.res_c          = c_q;
   assign bus.res_timeout    = to_q;
   assign bus.host2block_val = (state_q == S_REQ);
   assign bus.a_b_we_ext     = (state_q == S_WRITE);
   assign bus.a_data_in_ext  = (state_q == S_WRITE) ? a_q : '0;
   assign bus.b_data_in_ext  = (state_q == S_WRITE) ? b_q : '0;
   assign bus.block2host_rdy = (state_q == S_READ);
   assign bus.c_re_ext       = (state_q == S_READ);

endmodule

// File: tb/tb_mac_host_ctrl.sv
// Directed bench: dut1 (transpose on, long timeout) against a mac_top model,
// dut2 (pass-through, 16-cycle timeout) against a mac_top that never finishes.
module tb_mac_host_ctrl;
   import mac_pkg::*;

   localparam int unsigned D = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   mac_host_ctrl_if #(.M(4), .K(4), .N(4), .DWI(8), .DWF(16)) if1 ();
   mac_host_ctrl_if #(.M(4), .K(4), .N(4), .DWI(8), .DWF(16)) if2 ();

   mac_host_ctrl #(.TRANSPOSE_B(1'b1), .TIMEOUT_CYCLES(1024)) dut1 (
      .clk (clk), .rst (rst), .bus (if1.master));
   mac_host_ctrl #(.TRANSPOSE_B(1'b0), .TIMEOUT_CYCLES(16)) dut2 (
      .clk (clk), .rst (rst), .bus (if2.master));

   // mac_top model for dut1: B arrives already transposed (row j of B^T = column j of B)
   a_mat_t a_l;
   b_mat_t b_l;
   c_mat_t c_mod;
   logic   busy;
   int     d_cnt;

   always_comb begin
      c_mod = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++)
               c_mod[i*4+j] = c_mod[i*4+j] + 16'(a_l[i*4+k]) * 16'(b_l[j*4+k]);
   end

   always @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         d_cnt <= 0;
         a_l <= '0;
         b_l <= '0;
         if1.mac_done <= 1'b0;
         if1.c_data_out_ext <= '0;
      end else begin
         if (if1.a_b_we_ext) begin
            a_l <= if1.a_data_in_ext;
            b_l <= if1.b_data_in_ext;
            busy <= 1'b1;
            d_cnt <= 1;
         end else if (busy) begin
            d_cnt <= d_cnt + 1;
            if (d_cnt == D - 1) begin
               if1.mac_done <= 1'b1;
               busy <= 1'b0;
            end
         end
         if (if1.c_re_ext) begin
            if1.c_data_out_ext <= c_mod;
            if1.mac_done <= 1'b0;
         end
      end
   end

   assign if2.mac_done       = 1'b0;
   assign if2.block2host_val = 1'b0;
   assign if2.c_data_out_ext = {16{16'hBEEF}};
   assign if1.block2host_val = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic load_job1(input int scale);
      for (int i = 0; i < 16; i++) begin
         if1.job_a[i] = 8'(i * scale);
         if1.job_b[i] = 8'(i);
      end
   endtask

   task automatic wait_res1(input string tag);
      for (int n = 0; n < 100 && !if1.res_val; n++) step();
      chk(tag, {63'd0, if1.res_val}, 64'd1);
   endtask

   task automatic wait_we1(input string tag);
      for (int n = 0; n < 100 && !if1.a_b_we_ext; n++) step();
      chk(tag, {63'd0, if1.a_b_we_ext}, 64'd1);
   endtask

   c_mat_t snap;

   initial begin
      if1.job_val = 1'b0; if1.res_rdy = 1'b0; if1.host2block_rdy = 1'b1;
      if1.job_a = '0; if1.job_b = '0;
      if2.job_val = 1'b0; if2.res_rdy = 1'b0; if2.host2block_rdy = 1'b1;
      if2.job_a = '0; if2.job_b = '0;
      step(); step();
      rst = 1'b0;

      // reset state
      chk("rst_job_rdy", {63'd0, if1.job_rdy}, 64'd1);
      chk("rst_h2b_val", {63'd0, if1.host2block_val}, 64'd0);
      chk("rst_res_val", {63'd0, if1.res_val}, 64'd0);
      chk("rst_we", {63'd0, if1.a_b_we_ext}, 64'd0);
      chk("rst_c_re", {63'd0, if1.c_re_ext}, 64'd0);
      chk("rst_job_rdy2", {63'd0, if2.job_rdy}, 64'd1);

      // basic job
      load_job1(1);
      if1.job_val = 1'b1;
      step();
      if1.job_val = 1'b0;
      chk("req_h2b_val", {63'd0, if1.host2block_val}, 64'd1);
      chk("req_no_we", {63'd0, if1.a_b_we_ext}, 64'd0);
      step();
      chk("wr_we", {63'd0, if1.a_b_we_ext}, 64'd1);
      chk("wr_h2b_val", {63'd0, if1.host2block_val}, 64'd0);
      chk("wr_a5", 64'(if1.a_data_in_ext[5]), 64'd5);
      chk("wr_b1", 64'(if1.b_data_in_ext[1]), 64'd4);
      chk("wr_b4", 64'(if1.b_data_in_ext[4]), 64'd1);
      step();
      chk("wr_we_1cyc", {63'd0, if1.a_b_we_ext}, 64'd0);
      chk("a_zero_after", 64'(if1.a_data_in_ext[5]), 64'd0);
      wait_res1("basic_res_val");
      chk("basic_c0", 64'(if1.res_c[0]), 64'd56);
      chk("basic_c1", 64'(if1.res_c[1]), 64'd62);
      chk("basic_c15", 64'(if1.res_c[15]), 64'd506);
      chk("basic_to", {63'd0, if1.res_timeout}, 64'd0);

      // result backpressure with a pending job
      snap = if1.res_c;
      if1.job_val = 1'b1;
      for (int n = 0; n < 8; n++) begin
         step();
         chk("bp_res_val", {63'd0, if1.res_val}, 64'd1);
         chk("bp_res_c_stable", {63'd0, (if1.res_c === snap)}, 64'd1);
         chk("bp_job_rdy", {63'd0, if1.job_rdy}, 64'd0);
      end
      if1.res_rdy = 1'b1;
      if1.host2block_rdy = 1'b0;
      step();
      if1.res_rdy = 1'b0;
      chk("bp_res_val_drop", {63'd0, if1.res_val}, 64'd0);
      chk("bp_idle_job_rdy", {63'd0, if1.job_rdy}, 64'd1);
      chk("bp_not_yet_req", {63'd0, if1.host2block_val}, 64'd0);
      step();
      if1.job_val = 1'b0;
      chk("bp_accept_req", {63'd0, if1.host2block_val}, 64'd1);

      // request backpressure
      for (int n = 0; n < 20; n++) begin
         step();
         chk("rq_h2b_held", {63'd0, if1.host2block_val}, 64'd1);
         chk("rq_no_we", {63'd0, if1.a_b_we_ext}, 64'd0);
      end
      if1.host2block_rdy = 1'b1;
      step();
      chk("rq_we_next", {63'd0, if1.a_b_we_ext}, 64'd1);
      wait_res1("rq_res_val");
      chk("rq_c0", 64'(if1.res_c[0]), 64'd56);
      if1.res_rdy = 1'b1;
      step();
      if1.res_rdy = 1'b0;

      // reset in WAIT_DONE, then a fresh job
      if1.job_val = 1'b1;
      step();
      if1.job_val = 1'b0;
      wait_we1("mr_we");
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_job_rdy", {63'd0, if1.job_rdy}, 64'd1);
      chk("mr_h2b_val", {63'd0, if1.host2block_val}, 64'd0);
      chk("mr_we", {63'd0, if1.a_b_we_ext}, 64'd0);
      chk("mr_c_re", {63'd0, if1.c_re_ext}, 64'd0);
      chk("mr_b2h_rdy", {63'd0, if1.block2host_rdy}, 64'd0);
      chk("mr_res_val", {63'd0, if1.res_val}, 64'd0);
      chk("mr_b_zero", 64'(if1.b_data_in_ext[1]), 64'd0);
      load_job1(2);
      if1.job_val = 1'b1;
      step();
      if1.job_val = 1'b0;
      wait_res1("mr2_res_val");
      chk("mr2_c0", 64'(if1.res_c[0]), 64'd112);
      chk("mr2_c1", 64'(if1.res_c[1]), 64'd124);
      chk("mr2_c15", 64'(if1.res_c[15]), 64'd1012);
      chk("mr2_to", {63'd0, if1.res_timeout}, 64'd0);
      if1.res_rdy = 1'b1;
      step();
      if1.res_rdy = 1'b0;

      // pass-through B and timeout on dut2
      for (int i = 0; i < 16; i++) begin
         if2.job_a[i] = 8'(i);
         if2.job_b[i] = 8'(i);
      end
      if2.job_val = 1'b1;
      step();
      if2.job_val = 1'b0;
      step();
      chk("pt_we", {63'd0, if2.a_b_we_ext}, 64'd1);
      chk("pt_b1", 64'(if2.b_data_in_ext[1]), 64'd1);
      chk("pt_b4", 64'(if2.b_data_in_ext[4]), 64'd4);
      for (int n = 0; n < 100 && !if2.res_val; n++) step();
      chk("to_res_val", {63'd0, if2.res_val}, 64'd1);
      chk("to_flag", {63'd0, if2.res_timeout}, 64'd1);
      chk("to_res_c_zero", {63'd0, |if2.res_c}, 64'd0);
      chk("to_h2b_val", {63'd0, if2.host2block_val}, 64'd0);
      chk("to_we", {63'd0, if2.a_b_we_ext}, 64'd0);
      chk("to_c_re", {63'd0, if2.c_re_ext}, 64'd0);
      chk("to_b2h_rdy", {63'd0, if2.block2host_rdy}, 64'd0);
      if2.res_rdy = 1'b1;
      step();
      if2.res_rdy = 1'b0;
      chk("to_back_idle", {63'd0, if2.job_rdy}, 64'd1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
